// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: sequencer state encoding
// and register-file index constants used by hazard logic.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the EX instruction is a load whose destination is
// read by the instruction in ID. Register 0 is hardwired and never conflicts.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ra,
    input  logic [REG_W-1:0] rb,
    input  logic             use_ra,
    input  logic             use_rb,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             ex_rf_le,
    output logic             hazard
);

    logic rd_live;
    logic match_a;
    logic match_b;

    assign rd_live = ex_load & ex_rf_le & (ex_rd != REG_ZERO);
    assign match_a = use_ra & (ex_rd == ra);
    assign match_b = use_rb & (ex_rd == rb);
    assign hazard  = rd_live & (match_a | match_b);

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/squash controller for the 5-stage pipeline: drives the front-end load
// enable and the NOP-injection select, and counts stall and squash events.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_RA,
    input  logic [REG_W-1:0] ID_RB,
    input  logic             ID_USE_RA,
    input  logic             ID_USE_RB,
    input  logic [REG_W-1:0] EX_RD,
    input  logic             EX_L,
    input  logic             EX_RF_LE,
    input  logic             BR_TAKEN,
    input  logic             BR_NULLIFY,
    input  logic             HALT_REQ,
    output logic             LE,
    output logic             S,
    output logic             HALTED,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] NULL_CNT
);

    // One down-counter is shared by STALL and DRAIN; 8 bits covers any sane drain depth.
    localparam int SEQ_W = 8;

    seq_state_t       state_reg, state_next;
    logic [SEQ_W-1:0] seq_reg, seq_next;
    logic             hazard;
    logic             nullify;
    logic             le_core, s_core, halted_core;
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    load_use_detect u_detect (
        .ra       (ID_RA),
        .rb       (ID_RB),
        .use_ra   (ID_USE_RA),
        .use_rb   (ID_USE_RB),
        .ex_rd    (EX_RD),
        .ex_load  (EX_L),
        .ex_rf_le (EX_RF_LE),
        .hazard   (hazard)
    );

    assign nullify = BR_TAKEN & BR_NULLIFY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            seq_reg   <= '0;
        end else begin
            state_reg <= state_next;
            seq_reg   <= seq_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        seq_next    = seq_reg;
        le_core     = 1'b1;
        s_core      = 1'b0;
        halted_core = 1'b0;
        cnt_inc     = 2'b00;
        case (state_reg)
            RUN: begin
                // Halt outranks squash, which outranks stall.
                if (HALT_REQ) begin
                    le_core    = 1'b0;
                    s_core     = 1'b1;
                    state_next = DRAIN;
                    seq_next   = SEQ_W'(DRAIN_CYCLES);
                end else if (nullify) begin
                    s_core     = 1'b1;
                    cnt_inc[1] = 1'b1;
                end else if (hazard) begin
                    le_core    = 1'b0;
                    s_core     = 1'b1;
                    cnt_inc[0] = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_next = STALL;
                        seq_next   = SEQ_W'(STALL_CYCLES - 1);
                    end
                end
            end
            STALL: begin
                le_core    = 1'b0;
                s_core     = 1'b1;
                cnt_inc[0] = 1'b1;
                seq_next   = seq_reg - SEQ_W'(1);
                if (seq_reg == SEQ_W'(1)) begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                le_core  = 1'b0;
                s_core   = 1'b1;
                seq_next = seq_reg - SEQ_W'(1);
                if (seq_reg == SEQ_W'(1)) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                le_core     = 1'b0;
                s_core      = 1'b1;
                halted_core = 1'b1;
                if (!HALT_REQ) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Reset must freeze the front end immediately, not only after the next edge.
    assign LE     = le_core & ~reset;
    assign S      = s_core | reset;
    assign HALTED = halted_core & ~reset;

    // Index 0 counts load-use stall cycles, index 1 counts squashed delay slots.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && !(&cnt_reg[gi])) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign STALL_CNT = cnt_reg[0];
    assign NULL_CNT  = cnt_reg[1];

endmodule
